debug_bus_arbiter: RTL and testbench

//   Upstream of the DEBUG_BUS slave port: arbitrates N debug masters (e.g. JTAG debug unit, test

---
 rtl/debug_bus_pkg.sv | 18 +
 rtl/debug_bus_arbiter_chk.sv | 36 +++
 rtl/debug_bus_id_fifo.sv | 84 ++++++++
 rtl/debug_bus_arbiter.sv | 165 ++++++++++++++++
 tb/tb_debug_bus_arbiter.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/debug_bus_pkg.sv
// ---------------------------------------------------------------------------
// debug_bus_pkg
//   Shared constants and helpers for the DEBUG_BUS arbitration slice.
//   - DBG_DATA_WIDTH         : data width of the DEBUG_BUS (read and write)
//   - DBG_ADDR_WIDTH_DEFAULT : default DEBUG_BUS address width
//   - dbg_idx_width()        : width of an index into n entries, never below 1
// ---------------------------------------------------------------------------
package debug_bus_pkg;

    localparam int DBG_DATA_WIDTH         = 32;
    localparam int DBG_ADDR_WIDTH_DEFAULT = 15;

    // A single-entry space still needs a one-bit index so ports stay legal.
    function automatic int dbg_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debug_bus_arbiter_chk.sv
// ---------------------------------------------------------------------------
// debug_bus_arbiter_chk
//   Simulation-only protocol checks for debug_bus_arbiter.
//   Ports:
//     clk_i, rst_ni  clock, async active-low reset
//     i_gnt          per-master grant vector
//     i_rvalid       per-master response-valid vector
//     i_s_rvalid     downstream response valid
//     i_fifo_empty   no transaction outstanding
//   A downstream response with nothing outstanding is reported as a warning:
//   the arbiter drops it and carries on.
// ---------------------------------------------------------------------------
module debug_bus_arbiter_chk #(
    parameter int N_MASTERS = 2
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    input logic [N_MASTERS-1:0] i_gnt,
    input logic [N_MASTERS-1:0] i_rvalid,
    input logic                 i_s_rvalid,
    input logic                 i_fifo_empty
);

    // Sample the checks once per clock while out of reset.
    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert ($onehot0(i_gnt))
                else $error("debug_bus_arbiter: grant vector not one-hot: %b", i_gnt);
            assert ($onehot0(i_rvalid))
                else $error("debug_bus_arbiter: rvalid vector not one-hot: %b", i_rvalid);
            assert (!(i_s_rvalid && i_fifo_empty))
                else $warning("debug_bus_arbiter: s_rvalid_i with no outstanding transaction");
        end
    end

endmodule

// File: rtl/debug_bus_id_fifo.sv
// ---------------------------------------------------------------------------
// debug_bus_id_fifo
//   Small FIFO of master indices, one entry per granted transaction that is
//   still waiting for its response.
//   Ports:
//     clk_i, rst_ni  clock, async active-low reset
//     i_push         store i_push_idx at the tail
//     i_push_idx     master index to store
//     i_pop          drop the head entry (ignored when empty)
//     o_full         DEPTH entries stored
//     o_empty        no entries stored
//     o_head         index at the head (meaningless when empty)
//   Push and pop in the same cycle are both performed, also when full.
// ---------------------------------------------------------------------------
module debug_bus_id_fifo
    import debug_bus_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int IDX_W = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             i_push,
    input  logic [IDX_W-1:0] i_push_idx,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [IDX_W-1:0] o_head
);

    localparam int PTR_W = dbg_idx_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [IDX_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers wrap at DEPTH, so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Status flags and qualified push/pop strobes.
    always_comb begin
        o_full    = (r_count == CNT_W'(DEPTH));
        o_empty   = (r_count == {CNT_W{1'b0}});
        o_head    = r_mem[r_rd_ptr];
        w_do_push = i_push & (~o_full | i_pop);
        w_do_pop  = i_pop & ~o_empty;
    end

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {IDX_W{1'b0}};
            end
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_idx;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/debug_bus_arbiter.sv
// ---------------------------------------------------------------------------
// debug_bus_arbiter
//   Round-robin arbiter of N debug masters onto one DEBUG_BUS master port.
//   A request left waiting for s_gnt_i is locked to its master so the
//   downstream fields stay stable; responses are routed back in order using
//   a FIFO of granted master indices.
//   Ports:
//     clk_i, rst_ni                 clock, async active-low reset
//     m_req_i/m_addr_i/m_we_i/m_wdata_i   per-master request fields
//     m_gnt_o, m_rvalid_o           per-master grant / response valid
//     m_rdata_o                     response data, broadcast
//     s_req_o/s_addr_o/s_we_o/s_wdata_o   downstream request fields
//     s_gnt_i, s_rvalid_i, s_rdata_i      downstream grant / response
// ---------------------------------------------------------------------------
module debug_bus_arbiter
    import debug_bus_pkg::*;
#(
    parameter int N_MASTERS       = 2,
    parameter int ADDR_WIDTH      = DBG_ADDR_WIDTH_DEFAULT,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [N_MASTERS-1:0]                 m_req_i,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0]      m_addr_i,
    input  logic [N_MASTERS-1:0]                 m_we_i,
    input  logic [N_MASTERS*DBG_DATA_WIDTH-1:0]  m_wdata_i,
    output logic [N_MASTERS-1:0]                 m_gnt_o,
    output logic [N_MASTERS-1:0]                 m_rvalid_o,
    output logic [DBG_DATA_WIDTH-1:0]            m_rdata_o,
    output logic                                 s_req_o,
    output logic [ADDR_WIDTH-1:0]                s_addr_o,
    output logic                                 s_we_o,
    output logic [DBG_DATA_WIDTH-1:0]            s_wdata_o,
    input  logic                                 s_gnt_i,
    input  logic                                 s_rvalid_i,
    input  logic [DBG_DATA_WIDTH-1:0]            s_rdata_i
);

    localparam int IDX_W = dbg_idx_width(N_MASTERS);
    localparam int DW    = DBG_DATA_WIDTH;

    logic [IDX_W-1:0]     r_rr_ptr;
    logic                 r_lock_vld;
    logic [IDX_W-1:0]     r_lock_idx;

    logic [IDX_W:0]       w_cand;
    logic                 w_found;
    logic [IDX_W-1:0]     w_winner;
    logic [IDX_W-1:0]     w_rr_next;
    logic                 w_handshake;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [IDX_W-1:0]     w_fifo_head;
    logic [N_MASTERS-1:0] w_one;

    assign w_one = {{(N_MASTERS-1){1'b0}}, 1'b1};

    // Winner: locked master, else first requester at or after rr_ptr.
    always_comb begin
        w_winner = r_rr_ptr;
        w_found  = 1'b0;
        w_cand   = {(IDX_W+1){1'b0}};
        if (r_lock_vld) begin
            w_winner = r_lock_idx;
        end else begin
            for (int i = 0; i < N_MASTERS; i++) begin
                w_cand = {1'b0, r_rr_ptr} + (IDX_W+1)'(i);
                if (w_cand >= (IDX_W+1)'(N_MASTERS)) begin
                    w_cand = w_cand - (IDX_W+1)'(N_MASTERS);
                end else begin
                    w_cand = w_cand;
                end
                if (!w_found && m_req_i[w_cand[IDX_W-1:0]]) begin
                    w_winner = w_cand[IDX_W-1:0];
                    w_found  = 1'b1;
                end else begin
                    w_found  = w_found;
                end
            end
        end
    end

    // Downstream request path; a full FIFO blocks requests without looking at
    // this cycle's pop, keeping s_rvalid_i off the request path.
    always_comb begin
        s_req_o     = (|m_req_i) & ~w_fifo_full;
        w_handshake = s_req_o & s_gnt_i;
        s_addr_o    = {ADDR_WIDTH{1'b0}};
        s_we_o      = 1'b0;
        s_wdata_o   = {DW{1'b0}};
        for (int k = 0; k < N_MASTERS; k++) begin
            if (s_req_o && (w_winner == IDX_W'(k))) begin
                s_addr_o  = m_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                s_we_o    = m_we_i[k];
                s_wdata_o = m_wdata_i[k*DW +: DW];
            end else begin
                s_addr_o  = s_addr_o;
            end
        end
        if (w_handshake) begin
            m_gnt_o = w_one << w_winner;
        end else begin
            m_gnt_o = {N_MASTERS{1'b0}};
        end
        if (w_winner == IDX_W'(N_MASTERS - 1)) begin
            w_rr_next = {IDX_W{1'b0}};
        end else begin
            w_rr_next = w_winner + IDX_W'(1);
        end
    end

    // Response routing to the master at the FIFO head.
    always_comb begin
        m_rdata_o = s_rdata_i;
        if (s_rvalid_i && !w_fifo_empty) begin
            m_rvalid_o = w_one << w_fifo_head;
        end else begin
            m_rvalid_o = {N_MASTERS{1'b0}};
        end
    end

    // Round-robin pointer and request lock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr   <= {IDX_W{1'b0}};
            r_lock_vld <= 1'b0;
            r_lock_idx <= {IDX_W{1'b0}};
        end else if (w_handshake) begin
            r_rr_ptr   <= w_rr_next;
            r_lock_vld <= 1'b0;
        end else if (s_req_o) begin
            r_lock_vld <= 1'b1;
            r_lock_idx <= w_winner;
        end else begin
            r_lock_vld <= r_lock_vld;
        end
    end

    debug_bus_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .IDX_W (IDX_W)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .i_push     (w_handshake),
        .i_push_idx (w_winner),
        .i_pop      (s_rvalid_i),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty),
        .o_head     (w_fifo_head)
    );

    debug_bus_arbiter_chk #(
        .N_MASTERS (N_MASTERS)
    ) u_chk (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .i_gnt        (m_gnt_o),
        .i_rvalid     (m_rvalid_o),
        .i_s_rvalid   (s_rvalid_i),
        .i_fifo_empty (w_fifo_empty)
    );

endmodule

// File: tb/tb_debug_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_debug_bus_arbiter
//   Directed bench for debug_bus_arbiter (2 masters, 15-bit address,
//   2 outstanding). Inputs change 1 time unit after the rising edge and
//   outputs are compared 1 time unit later.
// ---------------------------------------------------------------------------
module tb_debug_bus_arbiter;

    localparam int N  = 2;
    localparam int AW = 15;
    localparam int MO = 2;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic [N-1:0]    m_req_i;
    logic [N*AW-1:0] m_addr_i;
    logic [N-1:0]    m_we_i;
    logic [N*32-1:0] m_wdata_i;
    logic [N-1:0]    m_gnt_o;
    logic [N-1:0]    m_rvalid_o;
    logic [31:0]     m_rdata_o;
    logic            s_req_o;
    logic [AW-1:0]   s_addr_o;
    logic            s_we_o;
    logic [31:0]     s_wdata_o;
    logic            s_gnt_i;
    logic            s_rvalid_i;
    logic [31:0]     s_rdata_i;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    logic [1:0]  exp_gnt [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
    logic [1:0]  exp_rv  [5] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10};
    logic [14:0] exp_adr [5] = '{15'h0030, 15'h0031, 15'h0030, 15'h0031, 15'h0000};

    debug_bus_arbiter #(
        .N_MASTERS       (N),
        .ADDR_WIDTH      (AW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .m_req_i    (m_req_i),
        .m_addr_i   (m_addr_i),
        .m_we_i     (m_we_i),
        .m_wdata_i  (m_wdata_i),
        .m_gnt_o    (m_gnt_o),
        .m_rvalid_o (m_rvalid_o),
        .m_rdata_o  (m_rdata_o),
        .s_req_o    (s_req_o),
        .s_addr_o   (s_addr_o),
        .s_we_o     (s_we_o),
        .s_wdata_o  (s_wdata_o),
        .s_gnt_i    (s_gnt_i),
        .s_rvalid_i (s_rvalid_i),
        .s_rdata_i  (s_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_m(input int k, input logic req, input logic [AW-1:0] addr,
                         input logic we, input logic [31:0] wdata);
        m_req_i[k]           = req;
        m_addr_i[k*AW +: AW] = addr;
        m_we_i[k]            = we;
        m_wdata_i[k*32 +: 32] = wdata;
    endtask

    task automatic idle_inputs();
        m_req_i    = '0;
        m_addr_i   = '0;
        m_we_i     = '0;
        m_wdata_i  = '0;
        s_gnt_i    = 1'b0;
        s_rvalid_i = 1'b0;
        s_rdata_i  = 32'h0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst_ni = 1'b0;
        cyc();
        cyc();
        rst_ni = 1'b1;
        #1;
    endtask

    initial begin
        // Reset state: request passes through, nothing granted or routed.
        idle_inputs();
        rst_ni = 1'b0;
        set_m(0, 1'b1, 15'h0010, 1'b0, 32'h0);
        #2;
        chk("rst_s_req", s_req_o, 1);
        chk("rst_gnt", m_gnt_o, 0);
        chk("rst_rvalid", m_rvalid_o, 0);
        chk("rst_s_addr", s_addr_o, 32'h0010);
        chk("rst_rr_ptr", dut.r_rr_ptr, 0);
        chk("rst_count", dut.u_fifo.r_count, 0);

        // 1: single read from m0.
        reset_dut();
        set_m(0, 1'b1, 15'h0010, 1'b0, 32'h0);
        s_gnt_i = 1'b1;
        #1;
        chk("t1_gnt", m_gnt_o, 2'b01);
        chk("t1_s_addr", s_addr_o, 32'h0010);
        chk("t1_s_we", s_we_o, 0);
        cyc();
        idle_inputs();
        s_rvalid_i = 1'b1;
        s_rdata_i  = 32'hDEADBEEF;
        #1;
        chk("t1_rvalid", m_rvalid_o, 2'b01);
        chk("t1_rdata", m_rdata_o, 32'hDEADBEEF);
        chk("t1_s_req_idle", s_req_o, 0);
        cyc();

        // 2: both masters requesting continuously; alternating grants.
        reset_dut();
        for (int c = 0; c < 5; c++) begin
            set_m(0, c < 4, 15'h0030, 1'b0, 32'h0);
            set_m(1, c < 4, 15'h0031, 1'b0, 32'h0);
            s_gnt_i    = (c < 4);
            s_rvalid_i = (c > 0);
            s_rdata_i  = 32'hA000_0000 + 32'(c);
            #1;
            chk($sformatf("t2_gnt_%0d", c), m_gnt_o, exp_gnt[c]);
            chk($sformatf("t2_rvalid_%0d", c), m_rvalid_o, exp_rv[c]);
            chk($sformatf("t2_s_addr_%0d", c), s_addr_o, exp_adr[c]);
            chk($sformatf("t2_rdata_%0d", c), m_rdata_o, 32'hA000_0000 + 32'(c));
            cyc();
        end
        idle_inputs();

        // 3: m1 write stalls; lock keeps fields while m0 arrives.
        reset_dut();
        set_m(1, 1'b1, 15'h0100, 1'b1, 32'h12345678);
        #1;
        chk("t3_gnt_c0", m_gnt_o, 0);
        chk("t3_addr_c0", s_addr_o, 32'h0100);
        chk("t3_we_c0", s_we_o, 1);
        chk("t3_wdata_c0", s_wdata_o, 32'h12345678);
        cyc();
        chk("t3_lock_vld", dut.r_lock_vld, 1);
        chk("t3_lock_idx", dut.r_lock_idx, 1);
        cyc();
        set_m(0, 1'b1, 15'h0020, 1'b0, 32'h0);
        #1;
        chk("t3_addr_c2", s_addr_o, 32'h0100);
        chk("t3_gnt_c2", m_gnt_o, 0);
        cyc();
        s_gnt_i = 1'b1;
        #1;
        chk("t3_gnt_c3", m_gnt_o, 2'b10);
        chk("t3_addr_c3", s_addr_o, 32'h0100);
        cyc();
        set_m(1, 1'b0, 15'h0, 1'b0, 32'h0);
        s_rvalid_i = 1'b1;
        #1;
        chk("t3_gnt_c4", m_gnt_o, 2'b01);
        chk("t3_addr_c4", s_addr_o, 32'h0020);
        chk("t3_rvalid_c4", m_rvalid_o, 2'b10);
        cyc();
        idle_inputs();
        s_rvalid_i = 1'b1;
        #1;
        chk("t3_rvalid_c5", m_rvalid_o, 2'b01);
        cyc();

        // 4: FIFO full blocks requests, even with a response in the same cycle.
        reset_dut();
        set_m(0, 1'b1, 15'h0040, 1'b0, 32'h0);
        set_m(1, 1'b1, 15'h0041, 1'b0, 32'h0);
        s_gnt_i = 1'b1;
        #1;
        chk("t4_gnt_c0", m_gnt_o, 2'b01);
        cyc();
        chk("t4_gnt_c1", m_gnt_o, 2'b10);
        cyc();
        chk("t4_count_full", dut.u_fifo.r_count, 2);
        chk("t4_s_req_full", s_req_o, 0);
        chk("t4_gnt_full", m_gnt_o, 0);
        chk("t4_addr_full", s_addr_o, 0);
        cyc();
        s_rvalid_i = 1'b1;
        #1;
        chk("t4_s_req_pop", s_req_o, 0);
        chk("t4_gnt_pop", m_gnt_o, 0);
        chk("t4_rvalid_pop", m_rvalid_o, 2'b01);
        cyc();
        chk("t4_gnt_resume", m_gnt_o, 2'b01);
        chk("t4_rvalid_resume", m_rvalid_o, 2'b10);
        cyc();
        idle_inputs();
        s_rvalid_i = 1'b1;
        #1;
        chk("t4_rvalid_last", m_rvalid_o, 2'b01);
        cyc();
        s_rvalid_i = 1'b0;
        #1;
        chk("t4_count_end", dut.u_fifo.r_count, 0);

        // 5: push and pop in the same cycle keep the count.
        reset_dut();
        set_m(0, 1'b1, 15'h0050, 1'b0, 32'h0);
        s_gnt_i = 1'b1;
        #1;
        chk("t5_gnt_c0", m_gnt_o, 2'b01);
        cyc();
        set_m(0, 1'b0, 15'h0, 1'b0, 32'h0);
        set_m(1, 1'b1, 15'h0051, 1'b0, 32'h0);
        s_rvalid_i = 1'b1;
        #1;
        chk("t5_gnt_c1", m_gnt_o, 2'b10);
        chk("t5_rvalid_c1", m_rvalid_o, 2'b01);
        cyc();
        chk("t5_count", dut.u_fifo.r_count, 1);
        idle_inputs();
        s_rvalid_i = 1'b1;
        #1;
        chk("t5_rvalid_c2", m_rvalid_o, 2'b10);
        cyc();

        // 6: reset with two outstanding discards them; stray rvalid is dropped.
        reset_dut();
        set_m(0, 1'b1, 15'h0060, 1'b0, 32'h0);
        s_gnt_i = 1'b1;
        cyc();
        cyc();
        chk("t6_count_pre", dut.u_fifo.r_count, 2);
        chk("t6_rr_pre", dut.r_rr_ptr, 1);
        idle_inputs();
        rst_ni = 1'b0;
        #1;
        chk("t6_count_async", dut.u_fifo.r_count, 0);
        cyc();
        rst_ni = 1'b1;
        #1;
        chk("t6_count_post", dut.u_fifo.r_count, 0);
        chk("t6_rr_post", dut.r_rr_ptr, 0);
        chk("t6_lock_post", dut.r_lock_vld, 0);
        s_rvalid_i = 1'b1;
        s_rdata_i  = 32'h0BAD_0BAD;
        #1;
        chk("t6_stray_rvalid", m_rvalid_o, 0);
        cyc();
        s_rvalid_i = 1'b0;
        #1;
        chk("t6_count_stray", dut.u_fifo.r_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
